// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pkg
//  Description : 640x480@60 VGA timing defaults, NES window geometry, RGB type
//                and the 64-entry NES 2C02 palette.
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam int VGA_H_TOTAL      = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL      = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
    localparam int VGA_H_SYNC_START = VGA_H_ACTIVE + VGA_H_FP;
    localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC;
    localparam int VGA_V_SYNC_START = VGA_V_ACTIVE + VGA_V_FP;
    localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC;

    localparam int VGA_X_OFFSET = 64;
    localparam bit VGA_SYNC_POL = 1'b0;

    localparam int NES_W = 256;
    localparam int NES_H = 240;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t PALETTE [64] = '{
        24'h7C7C7C, 24'h0000FC, 24'h0000BC, 24'h4428BC, 24'h940084, 24'hA80020, 24'hA81000, 24'h881400,
        24'h503000, 24'h007800, 24'h006800, 24'h005800, 24'h004058, 24'h000000, 24'h000000, 24'h000000,
        24'hBCBCBC, 24'h0078F8, 24'h0058F8, 24'h6844FC, 24'hD800CC, 24'hE40058, 24'hF83800, 24'hE45C10,
        24'hAC7C00, 24'h00B800, 24'h00A800, 24'h00A844, 24'h008888, 24'h000000, 24'h000000, 24'h000000,
        24'hF8F8F8, 24'h3CBCFC, 24'h6888FC, 24'h9878F8, 24'hF878F8, 24'hF85898, 24'hF87858, 24'hFCA044,
        24'hF8B800, 24'hB8F818, 24'h58D854, 24'h58F898, 24'h00E8D8, 24'h787878, 24'h000000, 24'h000000,
        24'hFFFFFF, 24'hA4E4FC, 24'hB8B8F8, 24'hD8B8F8, 24'hF8B8F8, 24'hF8A4C0, 24'hF0D0B0, 24'hFCE0A8,
        24'hF8D878, 24'hD8F878, 24'hB8F8B8, 24'hB8F8D8, 24'h00FCFC, 24'hF8D8F8, 24'h000000, 24'h000000
    };

endpackage
`default_nettype wire

// File: rtl/vga_timing.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing
//  Description : Raster counters with undelayed sync/blank decode and a
//                registered one-clock frame-end pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP
) (
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] o_hcount,
    output logic [9:0] o_vcount,
    output logic       o_hs_act,
    output logic       o_vs_act,
    output logic       o_blank_n,
    output logic       o_frame_end
);

    localparam logic [9:0] c_h_last   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] c_v_last   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] c_h_active = 10'(H_ACTIVE);
    localparam logic [9:0] c_v_active = 10'(V_ACTIVE);
    localparam logic [9:0] c_hs_start = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] c_hs_end   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] c_vs_start = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] c_vs_end   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] r_hcount;
    logic [9:0] r_vcount;
    logic       r_frame_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hcount    <= 10'd0;
            r_vcount    <= 10'd0;
            r_frame_end <= 1'b0;
        end else begin
            // Pulse lands on the clock after the raster enters the first blank line.
            r_frame_end <= (r_hcount == 10'd0) && (r_vcount == c_v_active);
            if (r_hcount == c_h_last) begin
                r_hcount <= 10'd0;
                r_vcount <= (r_vcount == c_v_last) ? 10'd0 : r_vcount + 10'd1;
            end else begin
                r_hcount <= r_hcount + 10'd1;
            end
        end
    end

    assign o_hcount    = r_hcount;
    assign o_vcount    = r_vcount;
    assign o_hs_act    = (r_hcount >= c_hs_start) && (r_hcount < c_hs_end);
    assign o_vs_act    = (r_vcount >= c_vs_start) && (r_vcount < c_vs_end);
    assign o_blank_n   = (r_hcount < c_h_active) && (r_vcount < c_v_active);
    assign o_frame_end = r_frame_end;

endmodule
`default_nettype wire

// File: rtl/vga_scanout.sv
`default_nettype none
// ============================================================================
//  Module      : vga_scanout
//  Description : Reads the NES frame buffer 2x-scaled into a centred window
//                and drives 24-bit VGA colour with sync aligned to the pixels.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_scanout
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter int X_OFFSET = VGA_X_OFFSET,
    parameter bit SYNC_POL = VGA_SYNC_POL
) (
    input  logic        vga_clock,
    input  logic        rst,
    input  logic [5:0]  q,
    output logic        rd,
    output logic [15:0] rd_addr,
    output logic        vga_frame_end,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank_n,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b
);

    localparam logic [9:0] c_win_start = 10'(X_OFFSET);
    localparam logic [9:0] c_win_end   = 10'(X_OFFSET + 2 * NES_W);
    localparam logic [9:0] c_v_active  = 10'(V_ACTIVE);

    logic [9:0] w_hcount;
    logic [9:0] w_vcount;
    logic       w_hs_act;
    logic       w_vs_act;
    logic       w_blank_n;
    logic       w_win;
    logic [7:0] w_x_nes;
    logic [7:0] w_y_nes;

    logic       r_win_d1;
    logic       r_hs_act_d1;
    logic       r_vs_act_d1;
    logic       r_blank_n_d1;
    logic       r_hs_d2;
    logic       r_vs_d2;
    logic       r_blank_n_d2;
    rgb_t       r_rgb;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk         (vga_clock),
        .rst         (rst),
        .o_hcount    (w_hcount),
        .o_vcount    (w_vcount),
        .o_hs_act    (w_hs_act),
        .o_vs_act    (w_vs_act),
        .o_blank_n   (w_blank_n),
        .o_frame_end (vga_frame_end)
    );

    // Halving both coordinates repeats every NES pixel on two clocks and two lines.
    always_comb begin
        w_win   = (w_hcount >= c_win_start) && (w_hcount < c_win_end) && (w_vcount < c_v_active);
        w_x_nes = 8'((w_hcount - c_win_start) >> 1);
        w_y_nes = 8'(w_vcount >> 1);
    end

    assign rd      = w_win;
    assign rd_addr = w_win ? {w_y_nes, w_x_nes} : 16'h0000;

    always_ff @(posedge vga_clock or posedge rst) begin
        if (rst) begin
            r_win_d1     <= 1'b0;
            r_hs_act_d1  <= 1'b0;
            r_vs_act_d1  <= 1'b0;
            r_blank_n_d1 <= 1'b0;
            r_hs_d2      <= ~SYNC_POL;
            r_vs_d2      <= ~SYNC_POL;
            r_blank_n_d2 <= 1'b0;
            r_rgb        <= '0;
        end else begin
            r_win_d1     <= w_win;
            r_hs_act_d1  <= w_hs_act;
            r_vs_act_d1  <= w_vs_act;
            r_blank_n_d1 <= w_blank_n;
            r_hs_d2      <= r_hs_act_d1 ? SYNC_POL : ~SYNC_POL;
            r_vs_d2      <= r_vs_act_d1 ? SYNC_POL : ~SYNC_POL;
            r_blank_n_d2 <= r_blank_n_d1;
            // q is only trusted when it answers a read issued one clock earlier.
            r_rgb        <= r_win_d1 ? PALETTE[q] : '0;
        end
    end

    assign vga_hs      = r_hs_d2;
    assign vga_vs      = r_vs_d2;
    assign vga_blank_n = r_blank_n_d2;
    assign vga_r       = r_rgb.r;
    assign vga_g       = r_rgb.g;
    assign vga_b       = r_rgb.b;

endmodule
`default_nettype wire

// File: tb/tb_vga_scanout.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_scanout
//  Description : Self-checking bench for vga_scanout with a short vertical
//                frame, random frame-buffer contents and a cycle-count model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_scanout;

    localparam int V_ACT = 6;
    localparam int V_FP  = 2;
    localparam int V_SY  = 2;
    localparam int V_BP  = 2;
    localparam int LINES = V_ACT + V_FP + V_SY + V_BP;
    localparam int LINE  = 800;
    localparam int FRAME = LINE * LINES;
    localparam int XOFF  = 64;

    localparam logic [23:0] PAL [64] = '{
        24'h7C7C7C, 24'h0000FC, 24'h0000BC, 24'h4428BC, 24'h940084, 24'hA80020, 24'hA81000, 24'h881400,
        24'h503000, 24'h007800, 24'h006800, 24'h005800, 24'h004058, 24'h000000, 24'h000000, 24'h000000,
        24'hBCBCBC, 24'h0078F8, 24'h0058F8, 24'h6844FC, 24'hD800CC, 24'hE40058, 24'hF83800, 24'hE45C10,
        24'hAC7C00, 24'h00B800, 24'h00A800, 24'h00A844, 24'h008888, 24'h000000, 24'h000000, 24'h000000,
        24'hF8F8F8, 24'h3CBCFC, 24'h6888FC, 24'h9878F8, 24'hF878F8, 24'hF85898, 24'hF87858, 24'hFCA044,
        24'hF8B800, 24'hB8F818, 24'h58D854, 24'h58F898, 24'h00E8D8, 24'h787878, 24'h000000, 24'h000000,
        24'hFFFFFF, 24'hA4E4FC, 24'hB8B8F8, 24'hD8B8F8, 24'hF8B8F8, 24'hF8A4C0, 24'hF0D0B0, 24'hFCE0A8,
        24'hF8D878, 24'hD8F878, 24'hB8F8B8, 24'hB8F8D8, 24'h00FCFC, 24'hF8D8F8, 24'h000000, 24'h000000
    };

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  q;
    logic        rd;
    logic [15:0] rd_addr;
    logic        fe;
    logic        hs;
    logic        vs;
    logic        bn;
    logic [7:0]  vr;
    logic [7:0]  vg;
    logic [7:0]  vb;

    logic [5:0]  mem [65536];
    int          total = 0;
    int          bad   = 0;
    int          n     = 0;
    int          hs_low, vs_low, bn_high, fe_cnt;

    always #20 clk = ~clk;

    vga_scanout #(
        .V_ACTIVE (V_ACT),
        .V_FP     (V_FP),
        .V_SYNC   (V_SY),
        .V_BP     (V_BP)
    ) dut (
        .vga_clock     (clk),
        .rst           (rst),
        .q             (q),
        .rd            (rd),
        .rd_addr       (rd_addr),
        .vga_frame_end (fe),
        .vga_hs        (hs),
        .vga_vs        (vs),
        .vga_blank_n   (bn),
        .vga_r         (vr),
        .vga_g         (vg),
        .vga_b         (vb)
    );

    // Registered RAM; junk on q whenever no read was issued.
    always @(posedge clk) q <= rd ? mem[rd_addr] : 6'($urandom);

    function automatic int hc(input int k); return k % LINE; endfunction
    function automatic int vc(input int k); return (k / LINE) % LINES; endfunction
    function automatic bit win(input int k);
        return hc(k) >= XOFF && hc(k) < XOFF + 512 && vc(k) < V_ACT;
    endfunction
    function automatic logic [15:0] addr(input int k);
        return win(k) ? 16'((vc(k) / 2) * 256 + (hc(k) - XOFF) / 2) : 16'h0000;
    endfunction

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s n=%0d observed=%h expected=%h", tag, n, obs, exp);
        end
    endtask

    task automatic check_reset();
        chk("rst_rd",      24'(rd),           24'h0);
        chk("rst_rd_addr", 24'(rd_addr),      24'h0);
        chk("rst_fe",      24'(fe),           24'h0);
        chk("rst_hs",      24'(hs),           24'h1);
        chk("rst_vs",      24'(vs),           24'h1);
        chk("rst_blank_n", 24'(bn),           24'h0);
        chk("rst_rgb",     {vr, vg, vb},      24'h0);
    endtask

    task automatic check_cycle();
        int  k;
        bit  e_hs, e_vs, e_bn;
        logic [23:0] e_rgb;
        chk("rd",        24'(rd),      24'(win(n)));
        chk("rd_addr",   24'(rd_addr), 24'(addr(n)));
        chk("frame_end", 24'(fe),      24'((n >= 1) && ((n - 1) % FRAME == V_ACT * LINE)));
        if (n < 2) begin
            e_hs = 1'b1; e_vs = 1'b1; e_bn = 1'b0; e_rgb = 24'h0;
        end else begin
            k     = n - 2;
            e_hs  = !(hc(k) >= 656 && hc(k) < 752);
            e_vs  = !(vc(k) >= V_ACT + V_FP && vc(k) < V_ACT + V_FP + V_SY);
            e_bn  = hc(k) < 640 && vc(k) < V_ACT;
            e_rgb = win(k) ? PAL[mem[addr(k)]] : 24'h0;
        end
        chk("hs",      24'(hs),      24'(e_hs));
        chk("vs",      24'(vs),      24'(e_vs));
        chk("blank_n", 24'(bn),      24'(e_bn));
        chk("rgb",     {vr, vg, vb}, e_rgb);
        if (n >= 2 && n < 2 + LINE) begin
            if (!hs) hs_low++;
            if (bn) bn_high++;
        end
        if (n >= 2 && n < 2 + FRAME && !vs) vs_low++;
        if (fe) fe_cnt++;
        // Directed boundary points with hand-computed values.
        if (n == 63 || n == 576)          chk("rd_border",   24'(rd),      24'h0);
        if (n == 64 || n == 65)           chk("addr_px64",   24'(rd_addr), 24'h0000);
        if (n == 66)                      chk("addr_px66",   24'(rd_addr), 24'h0001);
        if (n == 2 * LINE + 575)          chk("addr_l2_end", 24'(rd_addr), 24'h01FF);
        if (n == (V_ACT - 1) * LINE + 575) chk("addr_last",  24'(rd_addr), 24'h02FF);
        if (n == 66 || n == 67 || n == LINE + 66 || n == LINE + 67)
                                          chk("rgb_white",   {vr, vg, vb}, 24'hFFFFFF);
        if (n == 68)                      chk("rgb_black",   {vr, vg, vb}, 24'h000000);
        if (n == 657)                     chk("hs_pre_fall", 24'(hs),      24'h1);
        if (n == 658)                     chk("hs_fall",     24'(hs),      24'h0);
    endtask

    task automatic release_rst();
        rst     = 1'b0;
        n       = 0;
        hs_low  = 0;
        vs_low  = 0;
        bn_high = 0;
        fe_cnt  = 0;
        check_cycle();
    endtask

    task automatic run(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            check_cycle();
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 6'($urandom);
        mem[0] = 6'h30;
        mem[1] = 6'h0F;

        repeat (3) @(negedge clk);
        check_reset();
        release_rst();
        run(3000);

        // Reset held for 10 clocks in the middle of a frame.
        rst = 1'b1;
        #1;
        check_reset();
        repeat (10) begin
            @(negedge clk);
            check_reset();
        end
        release_rst();
        run(3 * FRAME + 10);
        chk("hs_low_per_line",   24'(hs_low),  24'd96);
        chk("blank_n_high_line", 24'(bn_high), 24'd640);
        chk("vs_low_per_frame",  24'(vs_low),  24'(2 * LINE));
        chk("frame_end_count",   24'(fe_cnt),  24'd3);

        // Reset mid-line at hcount 300 of line 3, then the first line again.
        run(3 * FRAME + 3 * LINE + 300 - n);
        rst = 1'b1;
        #1;
        check_reset();
        repeat (4) begin
            @(negedge clk);
            check_reset();
        end
        release_rst();
        run(2 * LINE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
